// File: rtl/alu_shift_pkg.sv
// Shared types and helpers for the sliced shift/rotate unit.
package alu_shift_pkg;

  typedef enum logic [2:0] {
    OP_RLC  = 3'd0,
    OP_RRC  = 3'd1,
    OP_RL   = 3'd2,
    OP_RR   = 3'd3,
    OP_SLA  = 3'd4,
    OP_SRA  = 3'd5,
    OP_SRL  = 3'd6,
    OP_SWAP = 3'd7
  } shift_op_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // Left modes walk the slices LSB-first; everything else (including SWAP) MSB-first.
  function automatic logic is_left(shift_op_t op);
    return (op == OP_RLC) || (op == OP_RL) || (op == OP_SLA);
  endfunction

  // Link bit entering the first slice; msb/lsb are the operand's end bits.
  function automatic logic init_link(shift_op_t op, logic msb, logic lsb, logic cin);
    case (op)
      OP_RLC, OP_SRA: return msb;
      OP_RRC:         return lsb;
      OP_RL, OP_RR:   return cin;
      default:        return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/shift_slice.sv
// Combinational one-slice shifter: shifts SLICE bits by one, link bit in and out.
module shift_slice #(
  parameter int SLICE = 4
) (
  input  logic [SLICE-1:0] s,
  input  logic             link,
  input  logic             dir,       // 1 = left, 0 = right
  output logic [SLICE-1:0] out,
  output logic             link_next
);

  generate
    if (SLICE == 1) begin : g_bit
      assign out       = link;
      assign link_next = s[0];
    end else begin : g_vec
      assign out       = dir ? {s[SLICE-2:0], link} : {link, s[SLICE-1:1]};
      assign link_next = dir ? s[SLICE-1] : s[0];
    end
  endgenerate

endmodule

// File: rtl/alu_shift_seq.sv
// Multi-cycle shift/rotate unit: one SLICE per clock, link bit carried between
// slices, result and flags published with a one-cycle done pulse.
module alu_shift_seq
  import alu_shift_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int SLICE = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] operand,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             link,
  output logic             flag_z,
  output logic             flag_c,
  output logic             flag_h,
  output logic             flag_n
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [CW-1:0] LAST = CW'(NSLICE - 1);

  typedef logic [NSLICE-1:0][SLICE-1:0] slices_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q;
  shift_op_t        op_q;
  logic [WIDTH-1:0] opnd_q;
  slices_t          work_q, work_d;
  logic             link_q, link_d;

  logic             accept, last, left, is_swap, c_d;
  logic [CW-1:0]    sidx;
  slices_t          opnd_sl, swap_sl;
  logic [SLICE-1:0] sl_out;
  logic             sl_link;

  assign accept  = start && (state_q == ST_IDLE);
  assign last    = (state_q == ST_RUN) && (cnt_q == LAST);
  assign left    = is_left(op_q);
  assign is_swap = (op_q == OP_SWAP);
  assign sidx    = left ? cnt_q : (LAST - cnt_q);
  assign opnd_sl = opnd_q;
  assign swap_sl = {opnd_q[WIDTH/2-1:0], opnd_q[WIDTH-1:WIDTH/2]};
  assign c_d     = left ? opnd_q[WIDTH-1] : (is_swap ? 1'b0 : opnd_q[0]);

  shift_slice #(.SLICE(SLICE)) u_slice (
    .s         (opnd_sl[sidx]),
    .link      (link_q),
    .dir       (left),
    .out       (sl_out),
    .link_next (sl_link)
  );

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept) state_d = ST_RUN;
      ST_RUN:  if (cnt_q == LAST) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // SWAP is a plain slice copy and leaves the link untouched.
  always_comb begin
    work_d       = work_q;
    work_d[sidx] = is_swap ? swap_sl[sidx] : sl_out;
    link_d       = is_swap ? link_q : sl_link;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q  <= '0;
      done   <= 1'b0;
      result <= '0;
      link_q <= 1'b0;
      flag_z <= 1'b0;
      flag_c <= 1'b0;
    end else begin
      done <= last;
      if (accept) begin
        cnt_q  <= '0;
        link_q <= init_link(shift_op_t'(op), operand[WIDTH-1], operand[0], cin);
      end else if (state_q == ST_RUN) begin
        cnt_q  <= cnt_q + 1'b1;
        link_q <= link_d;
      end
      if (last) begin
        result <= work_d;
        flag_z <= (work_d == '0);
        flag_c <= c_d;
      end
    end
  end

  // NOTE: operand/op/work registers are deliberately not reset: they are
  // always loaded before being read, so a reset would only add fan-out.
  always_ff @(posedge clk) begin
    if (accept) begin
      op_q   <= shift_op_t'(op);
      opnd_q <= operand;
    end
    if (state_q == ST_RUN) work_q <= work_d;
  end

  assign busy   = (state_q == ST_RUN);
  assign link   = link_q;
  assign flag_h = 1'b0;
  assign flag_n = 1'b0;

endmodule

// File: tb/tb_alu_shift_seq.sv
// Scoreboard bench: random and directed ops on an 8/4 instance, plus directed
// latency cases on 16/4 and 8/8 instances.
module tb_alu_shift_seq;
  import alu_shift_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int checks = 0;
  int failures = 0;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Main 8-bit / 4-bit-slice instance
  logic       start, cin, busy, done, link, flag_z, flag_c, flag_h, flag_n;
  logic [2:0] op_in;
  logic [7:0] operand, result;

  alu_shift_seq #(.WIDTH(8), .SLICE(4)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op_in), .operand(operand), .cin(cin),
    .busy(busy), .done(done), .result(result), .link(link),
    .flag_z(flag_z), .flag_c(flag_c), .flag_h(flag_h), .flag_n(flag_n)
  );

  // 16-bit / 4-bit-slice instance
  logic        s16, cin16, busy16, done16, link16, z16, c16, h16, n16;
  logic [2:0]  op16;
  logic [15:0] opnd16, res16;

  alu_shift_seq #(.WIDTH(16), .SLICE(4)) dut16 (
    .clk(clk), .reset(reset), .start(s16), .op(op16), .operand(opnd16), .cin(cin16),
    .busy(busy16), .done(done16), .result(res16), .link(link16),
    .flag_z(z16), .flag_c(c16), .flag_h(h16), .flag_n(n16)
  );

  // 8-bit / 8-bit-slice instance (single-cycle)
  logic       s8, cin8, busy8, done8, link8, z8, c8, h8, n8;
  logic [2:0] op8;
  logic [7:0] opnd8, res8;

  alu_shift_seq #(.WIDTH(8), .SLICE(8)) dut8 (
    .clk(clk), .reset(reset), .start(s8), .op(op8), .operand(opnd8), .cin(cin8),
    .busy(busy8), .done(done8), .result(res8), .link(link8),
    .flag_z(z8), .flag_c(c8), .flag_h(h8), .flag_n(n8)
  );

  typedef struct {
    logic [7:0] r;
    logic       c;
    logic       z;
    logic       lk;
    logic       chk_lk;
    int         acc;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;

  // Whole-word reference: the sliced unit must equal a single 1-bit shift/rotate.
  function automatic exp_t model(logic [2:0] o, logic [7:0] v, logic ci);
    exp_t e;
    e.chk_lk = 1'b1;
    e.acc    = 0;
    case (shift_op_t'(o))
      OP_RLC:  begin e.r = {v[6:0], v[7]}; e.c = v[7]; end
      OP_RRC:  begin e.r = {v[0], v[7:1]}; e.c = v[0]; end
      OP_RL:   begin e.r = {v[6:0], ci};   e.c = v[7]; end
      OP_RR:   begin e.r = {ci, v[7:1]};   e.c = v[0]; end
      OP_SLA:  begin e.r = v << 1;         e.c = v[7]; end
      OP_SRA:  begin e.r = {v[7], v[7:1]}; e.c = v[7-7]; end
      OP_SRL:  begin e.r = v >> 1;         e.c = v[0]; end
      default: begin e.r = {v[3:0], v[7:4]}; e.c = 1'b0; e.chk_lk = 1'b0; end
    endcase
    e.z  = (e.r == 8'h00);
    e.lk = e.c;   // the last bit pushed out of the word is the final link
    return e;
  endfunction

  function automatic logic exp_init_link(logic [2:0] o, logic [7:0] v, logic ci);
    case (shift_op_t'(o))
      OP_RLC, OP_SRA: return v[7];
      OP_RRC:         return v[0];
      OP_RL, OP_RR:   return ci;
      default:        return 1'b0;
    endcase
  endfunction

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!reset && done) begin
      if (sbq.size() == 0) begin
        check("unexpected_done", 64'(1), 64'(0));
      end else begin
        mon_e = sbq.pop_front();
        check("result",       64'(result), 64'(mon_e.r));
        check("flag_c",       64'(flag_c), 64'(mon_e.c));
        check("flag_z",       64'(flag_z), 64'(mon_e.z));
        check("flag_hn",      64'({flag_h, flag_n}), 64'(0));
        check("latency",      64'(cyc - mon_e.acc), 64'(2));
        check("busy_at_done", 64'(busy), 64'(0));
        if (mon_e.chk_lk) check("link_final", 64'(link), 64'(mon_e.lk));
      end
    end
  end

  // Called at a negedge. While the DUT is busy, start is held high with junk
  // values that must be ignored; the real request goes out once busy drops.
  task automatic issue(logic [2:0] o, logic [7:0] v, logic c);
    int   guard = 0;
    exp_t e;
    while (busy === 1'b1 && guard < 50) begin
      start   = 1'b1;
      op_in   = 3'($urandom_range(0, 7));
      operand = 8'($urandom);
      cin     = 1'($urandom_range(0, 1));
      @(negedge clk);
      guard++;
    end
    if (busy !== 1'b0) begin
      check("issue_timeout", 64'(1), 64'(0));
      start = 1'b0;
      return;
    end
    start   = 1'b1;
    op_in   = o;
    operand = v;
    cin     = c;
    e       = model(o, v, c);
    e.acc   = cyc + 1;
    sbq.push_back(e);
    @(negedge clk);
    check("busy_after_accept", 64'(busy), 64'(1));
    if (shift_op_t'(o) != OP_SWAP) check("link_init", 64'(link), 64'(exp_init_link(o, v, c)));
  endtask

  task automatic drain();
    int guard = 0;
    start = 1'b0;
    while ((sbq.size() != 0 || busy) && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    check("drain_outstanding", 64'(sbq.size()), 64'(0));
  endtask

  initial begin
    int n;
    reset = 1'b1;
    start = 1'b0; op_in = '0; operand = '0; cin = 1'b0;
    s16 = 1'b0; op16 = '0; opnd16 = '0; cin16 = 1'b0;
    s8  = 1'b0; op8  = '0; opnd8  = '0; cin8  = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_busy",   64'(busy),   64'(0));
    check("rst_done",   64'(done),   64'(0));
    check("rst_result", 64'(result), 64'(0));
    check("rst_link",   64'(link),   64'(0));
    check("rst_flags",  64'({flag_z, flag_c, flag_h, flag_n}), 64'(0));

    // 16/4: RL 0x8000 cin=1 takes four slices
    s16 = 1'b1; op16 = OP_RL; opnd16 = 16'h8000; cin16 = 1'b1;
    @(negedge clk);
    s16 = 1'b0; n = 0;
    check("w16_busy", 64'(busy16), 64'(1));
    while (!done16 && n < 20) begin @(negedge clk); n++; end
    check("w16_latency", 64'(n), 64'(4));
    check("w16_result",  64'(res16), 64'(16'h0001));
    check("w16_c",       64'(c16), 64'(1));
    check("w16_z",       64'(z16), 64'(0));

    // 8/8: RRC 0x01 completes in one slice
    s8 = 1'b1; op8 = OP_RRC; opnd8 = 8'h01; cin8 = 1'b0;
    @(negedge clk);
    s8 = 1'b0; n = 0;
    check("w8s8_busy", 64'(busy8), 64'(1));
    while (!done8 && n < 20) begin @(negedge clk); n++; end
    check("w8s8_latency", 64'(n), 64'(1));
    check("w8s8_result",  64'(res8), 64'(8'h80));
    check("w8s8_c",       64'(c8), 64'(1));

    // Directed cases, back-to-back with ignored starts between them
    issue(OP_RLC,  8'h85, 1'b0);
    issue(OP_RR,   8'h01, 1'b0);
    issue(OP_RL,   8'h80, 1'b1);
    issue(OP_SRA,  8'h81, 1'b0);
    issue(OP_SRL,  8'h81, 1'b0);
    issue(OP_SWAP, 8'hF1, 1'b1);
    issue(OP_SLA,  8'h80, 1'b0);
    issue(OP_SWAP, 8'h00, 1'b0);
    drain();

    for (int i = 0; i < 60; i++)
      issue(3'($urandom_range(0, 7)), 8'($urandom), 1'($urandom_range(0, 1)));
    drain();

    // Mid-operation reset, with start held high during reset
    issue(OP_RLC, 8'h85, 1'b0);
    void'(sbq.pop_back());
    reset = 1'b1;
    @(negedge clk);
    check("midrst_busy",   64'(busy),   64'(0));
    check("midrst_done",   64'(done),   64'(0));
    check("midrst_result", 64'(result), 64'(0));
    check("midrst_link",   64'(link),   64'(0));
    check("midrst_flags",  64'({flag_z, flag_c}), 64'(0));
    reset = 1'b0;
    start = 1'b0;
    @(negedge clk);
    check("rst_start_not_accepted", 64'(busy), 64'(0));
    repeat (4) @(negedge clk);
    check("midrst_result_held", 64'(result), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
